// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter with a one-entry holding register.
// - Clocked at OVERSAMPLE x baud; every serial bit lasts OVERSAMPLE clk cycles.
// - Frame: start(0), 8 data bits LSB first, [even parity], STOP_BITS stop bits(1).
// - Optional even-parity bit is compiled in with the macro UART_TX_PARITY_EN.
// - dbg_state exposes the FSM state for checkers.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrsig,
  input  logic [7:0] datain,
  output logic       tx,
  output logic       idle,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int STOP_LEN = STOP_BITS * OVERSAMPLE;
  localparam int CW       = $clog2(STOP_LEN);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  // Request/accept semantics: a request is a 0->1 edge of wrsig seen at a clk
  // edge (only after wrsig has been seen low since reset). It is accepted when
  // the holding register is empty, or when the holding register moves into the
  // shifter on that same edge; otherwise it is dropped and overrun pulses.
  logic          wrsig_q;
  logic          armed;
  logic          req;
  logic          accept;
  logic          load;
  logic          hold_full;
  logic          hold_full_next;
  logic [7:0]    hold_data;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_last;
  logic          bit_end;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift_q;
  logic [7:0]    shift_next;
  logic          tx_next;
  logic          idle_next;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  assign req            = wrsig & ~wrsig_q & armed;
  assign accept         = req & (~hold_full | load);
  assign hold_full_next = accept | (hold_full & ~load);
  assign cnt_last       = (state == ST_STOP) ? STOP_LAST : BIT_LAST;
  assign bit_end        = (cnt == cnt_last);
  assign idle_next      = (state_next == ST_IDLE) & ~hold_full_next;
  assign dbg_state      = state;

  // Register wrsig for edge detection; armed blocks a request until wrsig has been low after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrsig_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      wrsig_q <= wrsig;
      armed   <= armed | ~wrsig;
    end
  end

  // One-entry holding register: capture accepted requests, empty on transfer to the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else begin
      hold_full <= hold_full_next;
      if (accept) begin
        hold_data <= datain;
      end
    end
  end

  // FSM state, bit-time counter, shifter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift_q <= 8'h00;
      tx      <= 1'b1;
      idle    <= 1'b1;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift_q <= shift_next;
      tx      <= tx_next;
      idle    <= idle_next;
      overrun <= req & hold_full & ~load;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, latched when it moves into the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^hold_data;
    end
  end
`endif

  // Next-state, counter and shifter logic; tx_next is the line level for the next state.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_q;
    load         = 1'b0;
    tx_next      = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = ST_START;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next   = ST_DATA;
          cnt_next     = '0;
          bit_idx_next = 3'd0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (hold_full) begin
            // Back-to-back: next start bit directly follows the last stop cycle.
            load       = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    if (load) begin
      shift_next = hold_data;
    end

    unique case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par_q;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: clk cycles per serial bit (legal 4..64).
REQ-002 Parameter STOP_BITS, default 1: stop bits per frame (legal 1 or 2).
REQ-003 Port clk  input  1  bit-rate oversample clock (OVERSAMPLE x baud; 153.6 kHz for 9600 baud).
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port wrsig  input  1  send strobe; a 0->1 transition requests transmission of datain.
REQ-006 Port datain  input  8  byte to send, sampled on the clk edge where the wrsig rising edge is detected.
REQ-007 Port tx  output  1  serial line, idle high, registered.
REQ-008 Port idle  output  1  high when no frame is in progress and the holding register is empty.
REQ-009 Port overrun  output  1  one-cycle pulse when a request is dropped.

Function
REQ-010 Edge detection: a request SHALL be detected at a posedge clk where wrsig=1 and the previously registered wrsig=0; a held-high wrsig SHALL generate exactly one request.
REQ-011 One-entry holding register: on a request with the holding register empty, datain SHALL be captured into it on the detection edge.
REQ-012 FSM states IDLE, START, DATA, PARITY, STOP; each bit state SHALL last exactly OVERSAMPLE cycles, counted by a bit-time counter.
REQ-013 IDLE -> START one cycle after the holding register becomes full; on that transition the holding register SHALL move into the shifter and be marked empty; tx SHALL go 0 one cycle after the capture edge.
REQ-014 START (tx=0) -> DATA; DATA SHALL send 8 bits, LSB first, then -> PARITY if compiled in, otherwise -> STOP.
REQ-015 STOP SHALL hold tx=1 for STOP_BITS x OVERSAMPLE cycles.
REQ-016 STOP end: if the holding register is full -> START with no idle cycle (back-to-back); otherwise -> IDLE.
REQ-017 Frame length SHALL be (10 + STOP_BITS - 1) x OVERSAMPLE cycles, plus OVERSAMPLE when parity is enabled (default: 160 cycles without parity, 176 with).
REQ-018 Simultaneous events: a request on the same edge the holding register transfers to the shifter SHALL be accepted; it SHALL NOT be dropped.
REQ-019 A request with the holding register full and no transfer on that edge SHALL be dropped, SHALL leave the holding register contents unchanged, and SHALL pulse overrun for one cycle.
REQ-020 idle SHALL be registered and low from the cycle after a request capture until the last stop-bit cycle of the final frame ends.
REQ-021 datain changes while a frame is in progress SHALL NOT affect the frame.

Reset
REQ-022 On rst_n=0, asynchronously: tx=1, idle=1, overrun=0, FSM=IDLE, counters=0, holding register empty, registered wrsig=0.
REQ-023 Reset mid-frame SHALL abort the frame immediately (tx=1 without waiting for a clock), and no partial frame SHALL resume after release.
REQ-024 Reset release with wrsig already high SHALL NOT generate a request until wrsig falls and rises again.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, a PARITY state SHALL follow DATA and send even parity (XOR of the 8 data bits) for OVERSAMPLE cycles.
REQ-026 When UART_TX_PARITY_EN is undefined, no PARITY state or parity logic SHALL exist, and frames SHALL be 8N1 (or 8N2).

Verification
REQ-027 Default parameters, no parity, wrsig pulse with datain=8'h48 -> tx low 1 cycle later; tx sequence 0,0,0,0,1,0,0,1,0,1, each bit 16 cycles; idle returns high 160 cycles after tx falls.
REQ-028 Second strobe with datain=8'h65 sent mid-frame of 8'h48 -> 8'h65 start bit immediately follows the 8'h48 stop bit with zero gap; overrun stays 0.
REQ-029 Three strobes (8'h01, 8'h02, 8'h03) within one frame -> 8'h01 and 8'h02 are sent; 8'h03 is dropped with a single overrun pulse.
REQ-030 UART_TX_PARITY_EN defined, datain=8'h07 -> parity bit 1; datain=8'h03 -> parity bit 0; frame 176 cycles.
REQ-031 rst_n asserted during DATA bit 3 of 8'hAA -> tx=1 immediately, idle=1; after release tx stays high and no frame is sent until a new wrsig edge.
REQ-032 wrsig held high for 500 cycles with datain=8'h55 -> exactly one frame is sent, and overrun is never asserted.
